inverter_loopback_tester: RTL

Digital stimulus-and-check stage placed around the analog inverter cell. It drives the inverter input with a programmable square wave on stim_out. It takes the inverter output back in on sense_in, through an off-chip or pad loopback, and checks that sense follows the inverse of stim after a settle time. It counts mismatches and rising edges, then reports a pass/fail verdict per run.

---
 rtl/inverter_loopback_tester_if.sv | 31 +++
 rtl/inverter_loopback_tester.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/inverter_loopback_tester_if.sv
// Bus between the inverter loopback tester and whatever controls it.
//   master : drives ena/start/abort/div/num_periods and the looped-back
//            sense_in, observes stim_out/busy/done/pass/err_cnt/edge_cnt
//   slave  : the tester itself
interface inverter_loopback_tester_if #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
);
    logic             ena;
    logic             start;
    logic             abort;
    logic [DIV_W-1:0] div;
    logic [7:0]       num_periods;
    logic             sense_in;
    logic             stim_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] edge_cnt;

    modport master (
        output ena, start, abort, div, num_periods, sense_in,
        input  stim_out, busy, done, pass, err_cnt, edge_cnt
    );

    modport slave (
        input  ena, start, abort, div, num_periods, sense_in,
        output stim_out, busy, done, pass, err_cnt, edge_cnt
    );
endinterface

// File: rtl/inverter_loopback_tester.sv
// Stimulus-and-check stage around an analog inverter cell.
// Drives a square wave on stim_out, takes the inverter output back on
// sense_in (asynchronous), and checks that it follows ~stim_out SETTLE
// cycles after every toggle. Counts mismatches and sense rising edges and
// reports a pass/fail verdict at the end of each run.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of inverter_loopback_tester_if
//            (ena, start, abort, div, num_periods, sense_in in;
//             stim_out, busy, done, pass, err_cnt, edge_cnt out)
module inverter_loopback_tester #(
    parameter int DIV_W  = 8,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    inverter_loopback_tester_if.slave    bus
);
    // Half-period register must hold both any div value and SETTLE.
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int HP_W  = (DIV_W > SET_W) ? DIV_W : SET_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic             s1_q, s2_q, s3_q;
    logic             stim_q, busy_q, done_q, pass_q;
    logic [CNT_W-1:0] err_q, edge_q;
    logic [CNT_W-1:0] err_d, edge_d;
    logic [HP_W-1:0]  hp_m1_q, hp_m1_d;
    logic [HP_W-1:0]  hp_cnt_q;
    logic [HP_W-1:0]  div_ext;
    logic [8:0]       n_q, n_d;
    logic [9:0]       half_q;
    logic [9:0]       last_half;
    logic             cmp_hit, mism, rise, pass_d;

    always_comb begin
        div_ext   = HP_W'(bus.div);
        hp_m1_d   = (div_ext > HP_W'(SETTLE)) ? div_ext : HP_W'(SETTLE);
        n_d       = (bus.num_periods == 8'd0) ? 9'd256 : {1'b0, bus.num_periods};
        last_half = {n_q, 1'b0} - 10'd1;

        // hp_cnt_q counts cycles since the last toggle (0 on the toggle
        // cycle), so the compare lands exactly once per half-period. When
        // it coincides with the toggle edge, stim_q is still the old value.
        cmp_hit = (state_q == RUN) && (hp_cnt_q == HP_W'(SETTLE));
        mism    = (s2_q == stim_q);
        rise    = (state_q == RUN) && s2_q && !s3_q;

        err_d = err_q;
        if (cmp_hit && mism && (err_q != '1)) begin
            err_d = err_q + CNT_W'(1);
        end
        edge_d = edge_q;
        if (rise && (edge_q != '1)) begin
            edge_d = edge_q + CNT_W'(1);
        end

        // Verdict uses the post-update counts of the final RUN cycle.
        pass_d = (err_d == '0) && (edge_d == CNT_W'(n_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            stim_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            edge_q   <= '0;
            hp_m1_q  <= '0;
            hp_cnt_q <= '0;
            n_q      <= '0;
            half_q   <= '0;
        end else begin
            // Synchronizer and edge-detect history run even when disabled.
            s1_q <= bus.sense_in;
            s2_q <= s1_q;
            s3_q <= s2_q;

            if (bus.ena) begin
                done_q <= 1'b0;
                if (bus.abort) begin
                    state_q <= IDLE;
                    stim_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (bus.start) begin
                                err_q    <= '0;
                                edge_q   <= '0;
                                pass_q   <= 1'b0;
                                hp_m1_q  <= hp_m1_d;
                                n_q      <= n_d;
                                hp_cnt_q <= '0;
                                half_q   <= '0;
                                stim_q   <= 1'b1;
                                busy_q   <= 1'b1;
                                state_q  <= RUN;
                            end
                        end
                        RUN: begin
                            err_q  <= err_d;
                            edge_q <= edge_d;
                            if (hp_cnt_q == hp_m1_q) begin
                                hp_cnt_q <= '0;
                                if (half_q == last_half) begin
                                    // Last half-period is a stim=0 half, so
                                    // forcing 0 here adds no toggle.
                                    stim_q  <= 1'b0;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    pass_q  <= pass_d;
                                    state_q <= DONE;
                                end else begin
                                    stim_q <= ~stim_q;
                                    half_q <= half_q + 10'd1;
                                end
                            end else begin
                                hp_cnt_q <= hp_cnt_q + HP_W'(1);
                            end
                        end
                        DONE: begin
                            state_q <= IDLE;
                        end
                        default: begin
                            state_q <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.stim_out = stim_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_q;
    assign bus.edge_cnt = edge_q;

endmodule
